// File: rtl/des_fsm_pkg.sv
// Shared types and constants for the des_fsm level-driven toggle.
package des_fsm_pkg;

  typedef enum logic [0:0] {STATE_A = 1'b0, STATE_B = 1'b1} state_t;

  localparam state_t RESET_STATE    = STATE_B;
  localparam logic   SYNC_RESET_VAL = 1'b1;

  // in=1 holds, in=0 toggles; anything not decodable recovers to the reset state.
  function automatic state_t next_state(input state_t cur, input logic hold);
    state_t nxt;
    nxt = RESET_STATE;
    case (cur)
      STATE_A: nxt = hold ? STATE_A : STATE_B;
      STATE_B: nxt = hold ? STATE_B : STATE_A;
      default: nxt = RESET_STATE;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/des_fsm_sync.sv
// Generic 2-flop synchroniser; both stages reset asynchronously to rst_val.
module des_fsm_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic rst_val,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  // Next values for the two synchroniser stages.
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // Synchroniser stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= rst_val;
      sync_q <= rst_val;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/des_fsm.sv
// Two-state Moore toggle: holds while in=1, toggles while in=0, out=1 in state B.
// Define DES_FSM_IN_SYNC_EN to pass `in` through a 2-flop synchroniser first.
module des_fsm
  import des_fsm_pkg::*;
(
  input  logic clk,
  input  logic areset,
  input  logic in,
  output logic out
);

  logic   in_eff_s;
  state_t state_q, state_d;

`ifdef DES_FSM_IN_SYNC_EN
  // Resetting to the hold value keeps the first edges after reset from toggling.
  des_fsm_sync u_in_sync (
    .clk     (clk),
    .rst_n   (areset),
    .rst_val (SYNC_RESET_VAL),
    .d       (in),
    .q       (in_eff_s)
  );
`else
  assign in_eff_s = in;
`endif

  // Next-state logic.
  always_comb begin
    state_d = next_state(state_q, in_eff_s);
  end

  // State register.
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      state_q <= RESET_STATE;
    end else begin
      state_q <= state_d;
    end
  end

  assign out = (state_q == STATE_B);

endmodule

// File: tb/tb_des_fsm.sv
// Directed and randomized bench for des_fsm against a queue-based behavioural model.
module tb_des_fsm;

  logic clk    = 1'b0;
  logic areset = 1'b1;
  logic in     = 1'b1;
  logic out;

  always #5 clk = ~clk;

  des_fsm dut (
    .clk    (clk),
    .areset (areset),
    .in     (in),
    .out    (out)
  );

`ifdef DES_FSM_IN_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  int vectors     = 0;
  int miscompares = 0;

  // Model: m_b is 1 while in state B; m_pipe carries `in` values not yet seen by the state.
  bit m_b;
  bit m_pipe[$];

  task automatic model_reset();
    m_b = 1'b1;
    m_pipe.delete();
    for (int i = 0; i < LAT - 1; i++) m_pipe.push_back(1'b1);
  endtask

  task automatic model_edge(input bit i);
    bit eff;
    if (!areset) begin
      model_reset();
    end else begin
      m_pipe.push_back(i);
      eff = m_pipe.pop_front();
      if (!eff) m_b = !m_b;
    end
  endtask

  task automatic check(input string tag);
    logic expv;
    expv = m_b;
    vectors++;
    assert (out === expv) else begin
      miscompares++;
      $error("FAIL %s: out=%b expected=%b", tag, out, expv);
    end
  endtask

  // Called at a falling edge: drive in, take one rising edge, check at the next falling edge.
  task automatic tick(input bit i, input string tag);
    in = i;
    @(posedge clk);
    model_edge(i);
    @(negedge clk);
    check(tag);
  endtask

  initial begin
    model_reset();
    #1 areset = 1'b0;
    @(negedge clk);
    check("reset_state");
    in = 1'b0;
    @(posedge clk);
    model_edge(1'b0);
    @(negedge clk);
    check("reset_ignores_clk");

    // Release mid-cycle, then hold.
    areset = 1'b1;
    for (int k = 0; k < 5; k++) tick(1'b1, "hold");

    for (int k = 0; k < 4; k++) tick(1'b0, "toggle");

    tick(1'b0, "mixed0");
    tick(1'b1, "mixed1");
    tick(1'b1, "mixed2");
    tick(1'b0, "mixed3");
    tick(1'b1, "mixed4");

    // Walk into state A, then assert reset between edges.
    for (int k = 0; k < 4 && m_b; k++) tick(1'b0, "to_state_a");
    #2 areset = 1'b0;
    #1 model_reset();
    check("async_rst_immediate");
    @(negedge clk);
    for (int k = 0; k < 3; k++) tick(1'($urandom_range(0, 1)), "rst_held");

    // Release inside the edge's hold window: that edge must not act, the next one does.
    in = 1'b0;
    @(posedge clk);
    model_edge(1'b0);
    #1 areset = 1'b1;
    @(negedge clk);
    check("race_edge");
    tick(1'b0, "race_next");

    for (int k = 0; k < 80; k++) begin
      areset = ($urandom_range(0, 15) != 0);
      if (!areset) begin
        #1 model_reset();
        check("rand_async_rst");
      end
      tick(1'($urandom_range(0, 1)), "random");
    end
    areset = 1'b1;
    for (int k = 0; k < 6; k++) tick(1'($urandom_range(0, 1)), "random_tail");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
